// File: rtl/kp_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, idle/reset
// constants, the key code map and the single-press pattern test.
package kp_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } kp_state_e;

   localparam logic [3:0] KPC_RESET = 4'b0111;
   localparam logic [3:0] KPR_IDLE  = 4'hF;

   // True when exactly one of the four active-low lines is pulled low.
   function automatic logic is_one_cold(input logic [3:0] v);
      logic [3:0] z;
      z = ~v;
      return (z != 4'd0) && ((z & (z - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [3:0] key_map(input logic [3:0] kpr, input logic [3:0] kpc);
      logic [3:0] code;
      code = 4'h0;
      case ({kpr, kpc})
         8'b0111_1110: code = 4'hA;
         8'b0111_1101: code = 4'h3;
         8'b0111_1011: code = 4'h2;
         8'b0111_0111: code = 4'h1;
         8'b1011_1110: code = 4'hB;
         8'b1011_1101: code = 4'h6;
         8'b1011_1011: code = 4'h5;
         8'b1011_0111: code = 4'h4;
         8'b1101_1110: code = 4'hC;
         8'b1101_1101: code = 4'h9;
         8'b1101_1011: code = 4'h8;
         8'b1101_0111: code = 4'h7;
         8'b1110_1110: code = 4'hD;
         8'b1110_1101: code = 4'hF;
         8'b1110_1011: code = 4'h0;
         8'b1110_0111: code = 4'hE;
         default:      code = 4'h0;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/kp_sync.sv
// Two-flop synchronizer for the raw keypad rows; resets to the idle
// (all-high) pattern so no phantom press is seen out of reset.
module kp_sync
   import kp_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] d_i,
   output logic [3:0] q_o
);

   logic [3:0] meta_q;
   logic [3:0] sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= KPR_IDLE;
         sync_q <= KPR_IDLE;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/kp_scanner.sv
// Column scanner and press/release debouncer for a 4x4 active-low keypad.
// Emits one key_valid strobe with the key code per debounced press.
module kp_scanner
   import kp_pkg::*;
#(
   parameter int SCAN_DIV  = 50000,
   parameter int DB_CYCLES = 250000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] kpr,
   output logic [3:0] kpc,
   output logic       key_valid,
   output logic [3:0] key_num,
   output logic       key_down
);

   localparam int SCW = $clog2(SCAN_DIV) + 1;
   localparam int DBW = $clog2(DB_CYCLES) + 1;

   localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
   localparam logic [SCW-1:0] SETTLE    = SCW'(3);
   localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
   localparam logic [DBW-1:0] DB_MAX    = DBW'(DB_CYCLES);

   logic [3:0]     kpr_s;

   kp_state_e      state_q, state_d;
   logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
   logic [DBW-1:0] db_cnt_q, db_cnt_d;
   logic [3:0]     kpc_q, kpc_d;
   logic [3:0]     cap_kpr_q, cap_kpr_d;
   logic           key_valid_q, key_valid_d;
   logic [3:0]     key_num_q, key_num_d;
   logic           key_down_q, key_down_d;

   kp_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (kpr),
      .q_o   (kpr_s)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= SCAN;
         scan_cnt_q  <= '0;
         db_cnt_q    <= '0;
         kpc_q       <= KPC_RESET;
         cap_kpr_q   <= KPR_IDLE;
         key_valid_q <= 1'b0;
         key_num_q   <= 4'h0;
         key_down_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         scan_cnt_q  <= scan_cnt_d;
         db_cnt_q    <= db_cnt_d;
         kpc_q       <= kpc_d;
         cap_kpr_q   <= cap_kpr_d;
         key_valid_q <= key_valid_d;
         key_num_q   <= key_num_d;
         key_down_q  <= key_down_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      scan_cnt_d  = scan_cnt_q;
      db_cnt_d    = db_cnt_q;
      kpc_d       = kpc_q;
      cap_kpr_d   = cap_kpr_q;
      key_valid_d = 1'b0;
      key_num_d   = key_num_q;
      key_down_d  = key_down_q;

      case (state_q)
         SCAN: begin
            // A press seen after the settle window wins over a column advance,
            // so the captured column is the one that produced the row hit.
            if ((scan_cnt_q >= SETTLE) && is_one_cold(kpr_s)) begin
               cap_kpr_d = kpr_s;
               db_cnt_d  = '0;
               state_d   = DEBOUNCE;
            end else if (scan_cnt_q >= SCAN_LAST) begin
               scan_cnt_d = '0;
               kpc_d      = {kpc_q[0], kpc_q[3:1]};
            end else begin
               scan_cnt_d = scan_cnt_q + 1'b1;
            end
         end

         DEBOUNCE: begin
            if (kpr_s != cap_kpr_q) begin
               scan_cnt_d = '0;
               state_d    = SCAN;
            end else if (db_cnt_q >= DB_LAST) begin
               db_cnt_d    = DB_MAX;
               key_valid_d = 1'b1;
               key_num_d   = key_map(cap_kpr_q, kpc_q);
               key_down_d  = 1'b1;
               state_d     = HELD;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end

         HELD: begin
            if (kpr_s == KPR_IDLE) begin
               db_cnt_d = '0;
               state_d  = RELEASE;
            end
         end

         RELEASE: begin
            if (kpr_s != KPR_IDLE) begin
               state_d = HELD;
            end else if (db_cnt_q >= DB_LAST) begin
               db_cnt_d   = DB_MAX;
               key_down_d = 1'b0;
               scan_cnt_d = '0;
               state_d    = SCAN;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end

         default: begin
            scan_cnt_d = '0;
            state_d    = SCAN;
         end
      endcase
   end

   always_comb begin
      kpc       = kpc_q;
      key_valid = key_valid_q;
      key_num   = key_num_q;
      key_down  = key_down_q;
   end

endmodule
